// File: rtl/tmds_pkg.sv
// Shared constants for the DVI TMDS channel encoder: symbol/disparity widths
// and the four fixed control-period symbols.
package tmds_pkg;

  localparam int SYM_W = 10;
  localparam int CNT_W = 6;

  localparam logic [SYM_W-1:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [SYM_W-1:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [SYM_W-1:0] TMDS_CTRL_11 = 10'h2AB;

  function automatic logic [SYM_W-1:0] ctrl_symbol(input logic [1:0] c);
    logic [SYM_W-1:0] sym;
    case (c)
      2'b00:   sym = TMDS_CTRL_00;
      2'b01:   sym = TMDS_CTRL_01;
      2'b10:   sym = TMDS_CTRL_10;
      default: sym = TMDS_CTRL_11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/tmds_encoder_dvi_popcount8.sv
// Combinational population count of an 8-bit vector (result 0..8).
module popcount8 (
  input  logic [7:0] bits,
  output logic [3:0] count
);

  always_comb begin
    count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'b000, bits[i]};
    end
  end

endmodule

// File: rtl/tmds_encoder_dvi.sv
// One DVI TMDS colour channel: stage 1 transition-minimises the byte, stage 2
// DC-balances it against the running disparity. Two-cycle fixed latency.
module tmds_encoder_dvi
  import tmds_pkg::*;
(
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             de,
  input  logic [7:0]       din,
  input  logic [1:0]       ctrl,
  output logic [SYM_W-1:0] tmds
);

  // ---------------- stage 1: transition minimisation ----------------
  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] q_m_d, q_m_q;
  logic       de_d, de_q;
  logic [1:0] ctrl_d, ctrl_q;

  popcount8 u_pop_din (
    .bits  (din),
    .count (n1d)
  );

  always_comb begin
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !din[0]);
    q_m_d    = 9'd0;
    q_m_d[0] = din[0];
    for (int i = 1; i < 8; i++) begin
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ din[i]) : (q_m_d[i-1] ^ din[i]);
    end
    q_m_d[8] = ~use_xnor;
    de_d     = de;
    ctrl_d   = ctrl;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      q_m_q  <= 9'd0;
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      q_m_q  <= q_m_d;
      de_q   <= de_d;
      ctrl_q <= ctrl_d;
    end
  end

  // ---------------- stage 2: DC balance ----------------
  logic [3:0]              n1q, n0q;
  logic signed [CNT_W-1:0] disp_qm;
  logic signed [CNT_W-1:0] cnt_d, cnt_q;
  logic [SYM_W-1:0]        tmds_d, tmds_q;
  logic                    qm8;

  popcount8 u_pop_qm (
    .bits  (q_m_q[7:0]),
    .count (n1q)
  );

  assign n0q     = 4'd8 - n1q;
  assign qm8     = q_m_q[8];
  // Ones minus zeros of the byte; counts are widened unsigned before subtracting.
  assign disp_qm = $signed({2'b00, n1q}) - $signed({2'b00, n0q});

  always_comb begin
    cnt_d  = cnt_q;
    tmds_d = tmds_q;
    if (!de_q) begin
      cnt_d  = '0;
      tmds_d = ctrl_symbol(ctrl_q);
    end else if ((cnt_q == 0) || (n1q == n0q)) begin
      tmds_d = {~qm8, qm8, qm8 ? q_m_q[7:0] : ~q_m_q[7:0]};
      cnt_d  = qm8 ? (cnt_q + disp_qm) : (cnt_q - disp_qm);
    end else if (((cnt_q > 0) && (n1q > n0q)) || ((cnt_q < 0) && (n0q > n1q))) begin
      // Inverting the byte pulls disparity back toward zero.
      tmds_d = {1'b1, qm8, ~q_m_q[7:0]};
      cnt_d  = cnt_q + (qm8 ? 6'sd2 : 6'sd0) - disp_qm;
    end else begin
      tmds_d = {1'b0, qm8, q_m_q[7:0]};
      cnt_d  = cnt_q + disp_qm - (qm8 ? 6'sd0 : 6'sd2);
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      cnt_q  <= '0;
      tmds_q <= TMDS_CTRL_00;
    end else begin
      cnt_q  <= cnt_d;
      tmds_q <= tmds_d;
    end
  end

  assign tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Bench for tmds_encoder_dvi: directed symbol checks plus randomised traffic
// against a symbol-level reference encoder and decoder.
module tb_tmds_encoder_dvi;

  logic       clk_pix = 1'b0;
  logic       rst_pix = 1'b0;
  logic       de = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] ctrl = 2'b00;
  logic [9:0] tmds;

  int tests = 0;
  int fails = 0;
  int model_cnt = 0;
  int out_disp = 0;

  typedef struct {
    logic [9:0] exp;
    logic       de;
    logic [7:0] din;
    int         cnt;
    logic       has_k;
    logic [9:0] k_val;
  } ent_t;

  ent_t p1, p2;

  tmds_encoder_dvi dut (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .de      (de),
    .din     (din),
    .ctrl    (ctrl),
    .tmds    (tmds)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference encoder: minimise transitions, then invert whenever doing so
  // moves the running disparity of the emitted stream toward zero.
  task automatic model_encode(input logic d, input logic [7:0] dd, input logic [1:0] c,
                              output logic [9:0] sym);
    logic [7:0] qm;
    logic       qm8, use_xnor, invert;
    int         ones, bal;
    if (!d) begin
      model_cnt = 0;
      case (c)
        2'b00: sym = 10'h354;
        2'b01: sym = 10'h0AB;
        2'b10: sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
    end else begin
      ones     = $countones(dd);
      use_xnor = (ones > 4) || (ones == 4 && !dd[0]);
      qm[0]    = dd[0];
      for (int i = 1; i < 8; i++)
        qm[i] = use_xnor ? ~(qm[i-1] ^ dd[i]) : (qm[i-1] ^ dd[i]);
      qm8 = !use_xnor;
      bal = 2 * $countones(qm) - 8;
      if (model_cnt == 0 || bal == 0) invert = !qm8;
      else invert = (model_cnt > 0 && bal > 0) || (model_cnt < 0 && bal < 0);
      sym = {invert, qm8, invert ? ~qm : qm};
      model_cnt += 2 * $countones(sym) - 10;
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] sym);
    logic [7:0] d, o;
    d    = sym[9] ? ~sym[7:0] : sym[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++)
      o[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  task automatic check_entry(input ent_t e);
    chk10("symbol", tmds, e.exp);
    if (e.has_k) chk10("directed_symbol", tmds, e.k_val);
    if (e.de) begin
      chk10("decoded_byte", {2'b00, decode(tmds)}, {2'b00, e.din});
      out_disp += 2 * $countones(tmds) - 10;
      chk_int("stream_disparity", out_disp, e.cnt);
      chk_int("disparity_bound", int'(out_disp <= 16 && out_disp >= -16), 1);
    end else begin
      out_disp = 0;
    end
  endtask

  function automatic ent_t reset_entry();
    ent_t e;
    e.exp = 10'h354; e.de = 1'b0; e.din = 8'h00; e.cnt = 0;
    e.has_k = 1'b0; e.k_val = 10'h000;
    return e;
  endfunction

  task automatic cycle(input logic d, input logic [7:0] dd, input logic [1:0] c,
                       input logic has_k, input logic [9:0] k);
    ent_t e;
    logic [9:0] sym;
    @(negedge clk_pix);
    check_entry(p2);
    p2 = p1;
    de = d; din = dd; ctrl = c;
    model_encode(d, dd, c, sym);
    e.exp = sym; e.de = d; e.din = dd; e.cnt = model_cnt;
    e.has_k = has_k; e.k_val = k;
    p1 = e;
  endtask

  // Assert reset between edges and check the output clears without a clock.
  task automatic pulse_reset(input string tag);
    @(negedge clk_pix);
    rst_pix = 1'b1; de = 1'b1; din = 8'hA5; ctrl = 2'b11;
    #1 chk10(tag, tmds, 10'h354);
    repeat (2) @(negedge clk_pix);
    chk10({tag, "_held"}, tmds, 10'h354);
    rst_pix = 1'b0; de = 1'b0; din = 8'h00; ctrl = 2'b00;
    model_cnt = 0;
    out_disp  = 0;
    p1 = reset_entry();
    p2 = reset_entry();
  endtask

  initial begin
    p1 = reset_entry();
    p2 = reset_entry();

    // Reset before any clock edge.
    #2 rst_pix = 1'b1; de = 1'b1; din = 8'hA5;
    #1 chk10("reset_no_edge", tmds, 10'h354);
    repeat (2) @(negedge clk_pix);
    rst_pix = 1'b0; de = 1'b0; din = 8'h00; ctrl = 2'b00;
    repeat (3) cycle(1'b0, 8'h5A, 2'b00, 1'b1, 10'h354);

    // Control symbols.
    cycle(1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
    cycle(1'b0, 8'hFF, 2'b01, 1'b1, 10'h0AB);
    cycle(1'b0, 8'h00, 2'b10, 1'b1, 10'h154);
    cycle(1'b0, 8'h33, 2'b11, 1'b1, 10'h2AB);

    // Disparity tracking from cnt=0, ctrl ignored during data.
    cycle(1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
    cycle(1'b1, 8'h00, 2'b11, 1'b1, 10'h100);
    cycle(1'b1, 8'h00, 2'b10, 1'b1, 10'h3FF);
    cycle(1'b1, 8'h00, 2'b01, 1'b1, 10'h100);

    // XNOR path.
    cycle(1'b0, 8'hFF, 2'b00, 1'b1, 10'h354);
    cycle(1'b1, 8'hFF, 2'b00, 1'b1, 10'h200);

    // de drop after non-zero disparity, then restart.
    cycle(1'b1, 8'h00, 2'b00, 1'b0, 10'h000);
    cycle(1'b1, 8'h01, 2'b00, 1'b0, 10'h000);
    cycle(1'b0, 8'h77, 2'b00, 1'b1, 10'h354);
    cycle(1'b1, 8'h00, 2'b00, 1'b1, 10'h100);
    cycle(1'b1, 8'h00, 2'b00, 1'b1, 10'h3FF);

    // Reset mid-stream with data in both stages.
    cycle(1'b1, 8'h10, 2'b00, 1'b0, 10'h000);
    cycle(1'b1, 8'h00, 2'b00, 1'b0, 10'h000);
    pulse_reset("reset_mid_stream");
    cycle(1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
    cycle(1'b1, 8'h00, 2'b00, 1'b1, 10'h100);

    // Randomised traffic with mostly-long data runs.
    for (int n = 0; n < 10000; n++) begin
      cycle(($urandom_range(0, 9) != 0), 8'($urandom), 2'($urandom), 1'b0, 10'h000);
    end

    // Drain the pipeline.
    repeat (2) cycle(1'b0, 8'h00, 2'b00, 1'b1, 10'h354);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
